// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
//   One requester port of the data memory arbiter. The CPU load/store unit and
//   the host loader each connect through their own instance.
//
//   req     requester -> arbiter  transfer request, held until gnt
//   we      requester -> arbiter  1 = write, 0 = read
//   addr    requester -> arbiter  word address
//   wdata   requester -> arbiter  write data
//   gnt     arbiter -> requester  transfer accepted this cycle (combinational)
//   rvalid  arbiter -> requester  rdata valid, cycle after a read grant
//   rdata   arbiter -> requester  registered read data
//
//   master: requester view, slave: arbiter view.
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the write-port / async-read-port data memory between the CPU
//   load/store unit and the host loader. Round-robin arbitration with one
//   transfer per cycle; read data is registered and returned one cycle after
//   the grant. Out-of-range accesses (addr >= DEPTH) never write memory, read
//   back as zero and set a sticky error flag.
//
//   clk             in   clock, all state on posedge
//   rst             in   synchronous reset, active high
//   cpu             slave port of data_mem_arbiter_if (CPU load/store unit)
//   host            slave port of data_mem_arbiter_if (host loader)
//   mem_read_addr   out  read address to data_mem
//   mem_write_addr  out  write address to data_mem
//   mem_data        out  write data to data_mem
//   mem_WE          out  write enable to data_mem
//   mem_read        in   asynchronous read data from data_mem
//   oob_err         out  sticky: an out-of-range access was granted
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.slave    cpu,
    data_mem_arbiter_if.slave    host,
    output logic [ADDR_W-1:0]    mem_read_addr,
    output logic [ADDR_W-1:0]    mem_write_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 mem_WE,
    input  logic [DATA_W-1:0]    mem_read,
    output logic                 oob_err
);

    typedef enum logic {
        SIDE_CPU  = 1'b0,
        SIDE_HOST = 1'b1
    } side_e;

    // One extra bit so the limit is representable even when DEPTH == 2**ADDR_W;
    // the compare covers every address bit, so nothing aliases into range.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    side_e             last_grant;
    logic              cpu_gnt;
    logic              host_gnt;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    logic              cpu_rvalid_q;
    logic              host_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              oob_err_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (cpu.req && host.req) begin
                // Contention: the side that did not win last time goes now.
                cpu_gnt  = (last_grant == SIDE_HOST);
                host_gnt = (last_grant == SIDE_CPU);
            end else begin
                cpu_gnt  = cpu.req;
                host_gnt = host.req;
            end
        end

        any_gnt = cpu_gnt | host_gnt;

        // The host only steers the memory bus while granted; otherwise the
        // CPU inputs pass through (harmless, mem_WE stays low).
        sel_we    = host_gnt ? host.we    : cpu.we;
        sel_addr  = host_gnt ? host.addr  : cpu.addr;
        sel_wdata = host_gnt ? host.wdata : cpu.wdata;

        in_range = ({1'b0, sel_addr} < DEPTH_LIM);

        mem_read_addr  = sel_addr;
        mem_write_addr = sel_addr;
        mem_data       = sel_wdata;
        mem_WE         = any_gnt & sel_we & in_range;

        rd_word = in_range ? mem_read : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset is sampled synchronously; the grant logic above also
            // holds every grant low while rst is high, dropping pending requests.
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            oob_err_q     <= 1'b0;
            last_grant    <= SIDE_HOST;
        end else begin
            // rvalid is a one-cycle pulse per granted read; rdata holds otherwise.
            cpu_rvalid_q  <= cpu_gnt & ~cpu.we;
            host_rvalid_q <= host_gnt & ~host.we;

            if (cpu_gnt && !cpu.we) begin
                cpu_rdata_q <= rd_word;
            end
            if (host_gnt && !host.we) begin
                host_rdata_q <= rd_word;
            end

            if (any_gnt) begin
                last_grant <= host_gnt ? SIDE_HOST : SIDE_CPU;
                if (!in_range) begin
                    oob_err_q <= 1'b1;
                end
            end
        end
    end

    assign cpu.gnt     = cpu_gnt;
    assign host.gnt    = host_gnt;
    assign cpu.rvalid  = cpu_rvalid_q;
    assign host.rvalid = host_rvalid_q;
    assign cpu.rdata   = cpu_rdata_q;
    assign host.rdata  = host_rdata_q;
    assign oob_err     = oob_err_q;

endmodule
